// File: rtl/pong_pkg.sv
// ----------------------------------------------------------------------------
// pong_pkg : shared timing constants and auto-repeat state encoding
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pong_pkg;

  localparam int DEBOUNCE_10MS_50MHZ = 500000;
  localparam int HOLD_500MS          = 25000000;
  localparam int REPEAT_100MS        = 5000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_pb_ch.sv
// ----------------------------------------------------------------------------
// debounce_pb_ch : one button channel - sync, debounce, press/release pulses,
//                  hold-to-auto-repeat
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module debounce_pb_ch
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CLKS = DEBOUNCE_10MS_50MHZ,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CLKS     = HOLD_500MS,
  parameter int REPEAT_CLKS   = REPEAT_100MS
) (
  input  logic in_clk,
  input  logic rst_n,
  input  logic pb_in,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release,
  output logic pb_repeat
);

  localparam int              CNT_W      = $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [CNT_W-1:0] c_DB_LAST = CNT_W'(DEBOUNCE_CLKS - 1);
  localparam logic            c_IDLE_PIN = (ACTIVE_LOW != 0);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_p;
  logic             w_diff;
  logic             w_accept;
  logic             w_press_edge;
  logic             w_release_edge;

  assign w_p            = r_sync2 ^ c_IDLE_PIN;
  assign w_diff         = (w_p != r_level);
  assign w_accept       = w_diff && (r_cnt == c_DB_LAST);
  assign w_press_edge   = w_accept &&  w_p;
  assign w_release_edge = w_accept && !w_p;

  // Any agreeing sample restarts the count, so only an unbroken run is accepted.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= c_IDLE_PIN;
      r_sync2   <= c_IDLE_PIN;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= pb_in;
      r_sync2   <= r_sync1;
      r_press   <= w_press_edge;
      r_release <= w_release_edge;
      if (w_accept) begin
        r_level <= w_p;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign pb_level   = r_level;
  assign pb_press   = r_press;
  assign pb_release = r_release;

  if (REPEAT_EN != 0) begin : g_rep
    localparam int             H_W         = $clog2(max_int(HOLD_CLKS, REPEAT_CLKS) + 1);
    localparam logic [H_W-1:0] c_HOLD_LAST = H_W'(HOLD_CLKS - 1);
    localparam logic [H_W-1:0] c_REP_LAST  = H_W'(REPEAT_CLKS - 1);

    rep_state_e     r_state;
    rep_state_e     w_state_nx;
    logic [H_W-1:0] r_hcnt;
    logic [H_W-1:0] w_hcnt_nx;
    logic           r_rpt;
    logic           w_rpt_nx;

    always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_hcnt  <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_hcnt  <= w_hcnt_nx;
        r_rpt   <= w_rpt_nx;
      end
    end

    // Release wins over a coincident repeat slot.
    always_comb begin
      w_state_nx = r_state;
      w_hcnt_nx  = r_hcnt;
      w_rpt_nx   = 1'b0;
      if (w_release_edge) begin
        w_state_nx = IDLE;
        w_hcnt_nx  = '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_press_edge) begin
              w_state_nx = HOLD;
              w_hcnt_nx  = '0;
            end
          end
          HOLD: begin
            if (r_hcnt == c_HOLD_LAST) begin
              w_rpt_nx   = 1'b1;
              w_hcnt_nx  = '0;
              w_state_nx = REPEAT;
            end else begin
              w_hcnt_nx  = r_hcnt + H_W'(1);
            end
          end
          REPEAT: begin
            if (r_hcnt == c_REP_LAST) begin
              w_rpt_nx  = 1'b1;
              w_hcnt_nx = '0;
            end else begin
              w_hcnt_nx = r_hcnt + H_W'(1);
            end
          end
          default: begin
            w_state_nx = IDLE;
            w_hcnt_nx  = '0;
          end
        endcase
      end
    end

    assign pb_repeat = r_rpt;
  end else begin : g_norep
    assign pb_repeat = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/debounce_pb_multi.sv
// ----------------------------------------------------------------------------
// debounce_pb_multi : N_CH independent debounced pushbutton channels
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module debounce_pb_multi
  import pong_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DEBOUNCE_CLKS = DEBOUNCE_10MS_50MHZ,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CLKS     = HOLD_500MS,
  parameter int REPEAT_CLKS   = REPEAT_100MS
) (
  input  logic            in_clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_repeat
);

  if (N_CH < 1 || DEBOUNCE_CLKS < 1 || HOLD_CLKS < 1 || REPEAT_CLKS < 1) begin : g_param_err
    $error("debounce_pb_multi: N_CH and all count parameters must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_pb_ch #(
      .DEBOUNCE_CLKS (DEBOUNCE_CLKS),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_CLKS     (HOLD_CLKS),
      .REPEAT_CLKS   (REPEAT_CLKS)
    ) u_ch (
      .in_clk     (in_clk),
      .rst_n      (rst_n),
      .pb_in      (pb_in[i]),
      .pb_level   (pb_level[i]),
      .pb_press   (pb_press[i]),
      .pb_release (pb_release[i]),
      .pb_repeat  (pb_repeat[i])
    );
  end

endmodule

`default_nettype wire
